// File: rtl/bcd_pkg.sv
// Shared widths, default MM:SS moduli and per-digit modulus helpers for the BCD chain counter.
package bcd_pkg;

   localparam int DIGIT_W = 4;
   localparam int MAX_MOD = 10;
   localparam logic [15:0] MMSS_MODULI = 16'h6A6A;

   typedef logic [DIGIT_W-1:0] digit_t;

   function automatic digit_t mod_of(input logic [63:0] moduli, input int idx);
      return moduli[DIGIT_W*idx +: DIGIT_W];
   endfunction

   function automatic digit_t term_val(input logic [63:0] moduli, input int idx);
      return mod_of(moduli, idx) - 4'd1;
   endfunction

endpackage

// File: rtl/bcd_chain_counter_digit.sv
// One BCD digit of configurable modulus; counts a single step when cin is high and
// raises cout when that step rolls the digit past its terminal value.
module bcd_digit
   import bcd_pkg::*;
#(
   parameter digit_t MOD = 4'd10
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   cin,
   input  logic   up,
   input  logic   load,
   input  digit_t d,
   output digit_t q,
   output logic   cout
);

   localparam digit_t TERM = MOD - 4'd1;

   if ((MOD < 4'd2) || (MOD > 4'(MAX_MOD))) begin : g_bad_mod
      $error("bcd_digit: MOD %0d outside 2..10", MOD);
   end

   digit_t q_q;
   digit_t q_d;
   logic   at_term_s;

   // Next digit value and ripple carry/borrow out.
   always_comb begin
      at_term_s = up ? (q_q == TERM) : (q_q == 4'd0);
      cout      = cin & at_term_s;
      q_d       = q_q;
      if (load) begin
         if (d < MOD) begin
            q_d = d;
         end else begin
            q_d = 4'd0;
         end
      end else if (cin) begin
         if (up) begin
            q_d = at_term_s ? 4'd0 : (q_q + 4'd1);
         end else begin
            q_d = at_term_s ? TERM : (q_q - 4'd1);
         end
      end else begin
         q_d = q_q;
      end
   end

   // Digit register.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= 4'd0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/bcd_chain_counter.sv
// Cascade of BCD digits with per-digit moduli, up/down counting and parallel load.
// Defining BCD_CHAIN_SATURATE_EN makes down counting stop at zero instead of wrapping.
module bcd_chain_counter
   import bcd_pkg::*;
#(
   parameter int                  DIGITS = 4,
   parameter logic [4*DIGITS-1:0] MODULI = MMSS_MODULI
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  tc,
   output logic                  wrap,
   output logic                  zero
);

   localparam logic [63:0]         MODULI_EXT = 64'(MODULI);
   localparam logic [4*DIGITS-1:0] ONE_VAL    = {{(4*DIGITS-1){1'b0}}, 1'b1};

   logic [DIGITS:0] carry_s;
   logic            step_s;
   logic            sat_hold_s;
   logic            all_zero_s;
   logic            one_s;
   logic            load_zero_s;
   logic            wrap_d;
   logic            wrap_q;
   logic            zero_d;
   logic            zero_q;

   // Step qualification, terminal count and the next wrap/zero flags.
   always_comb begin
      all_zero_s = (bcd == {(4*DIGITS){1'b0}});
      one_s      = (bcd == ONE_VAL);
`ifdef BCD_CHAIN_SATURATE_EN
      sat_hold_s = ~up & all_zero_s;
      step_s     = en & ~load & ~sat_hold_s;
      tc         = up ? carry_s[DIGITS] : (step_s & one_s);
`else
      sat_hold_s = 1'b0;
      step_s     = en & ~load & ~sat_hold_s;
      tc         = carry_s[DIGITS];
`endif
      load_zero_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((load_val[4*i +: 4] <= term_val(MODULI_EXT, i)) && (load_val[4*i +: 4] != 4'd0)) begin
            load_zero_s = 1'b0;
         end else begin
            load_zero_s = load_zero_s;
         end
      end
      wrap_d = tc;
      if (load) begin
         zero_d = load_zero_s;
      end else if (step_s) begin
         // Counting up lands on zero only via a full rollover; down only from 00..01.
         zero_d = up ? carry_s[DIGITS] : one_s;
      end else begin
         zero_d = zero_q;
      end
   end

   assign carry_s[0] = step_s;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit #(
         .MOD (mod_of(MODULI_EXT, g))
      ) u_digit (
         .clk   (clk),
         .reset (reset),
         .cin   (carry_s[g]),
         .up    (up),
         .load  (load),
         .d     (load_val[4*g +: 4]),
         .q     (bcd[4*g +: 4]),
         .cout  (carry_s[g+1])
      );
   end

   // Wrap pulse and zero flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrap_q <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         wrap_q <= wrap_d;
         zero_q <= zero_d;
      end
   end

   assign wrap = wrap_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed bench for bcd_chain_counter: default MM:SS chain plus a 3-digit mod-200 chain.
module tb_bcd_chain_counter;

   logic        clk;
   logic        reset, en, up, load;
   logic [15:0] load_val, bcd;
   logic        tc, wrap, zero;

   logic        reset3, en3, up3, load3;
   logic [11:0] load_val3, bcd3;
   logic        tc3, wrap3, zero3;

   int n_cmp;
   int n_err;
   int wraps3;

   bcd_chain_counter u_dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .bcd(bcd), .tc(tc), .wrap(wrap), .zero(zero)
   );

   bcd_chain_counter #(.DIGITS(3), .MODULI(12'h2AA)) u_dut3 (
      .clk(clk), .reset(reset3), .en(en3), .up(up3), .load(load3),
      .load_val(load_val3), .bcd(bcd3), .tc(tc3), .wrap(wrap3), .zero(zero3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; wraps3 = 0;
      reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
      reset3 = 1'b1; en3 = 1'b0; up3 = 1'b1; load3 = 1'b0; load_val3 = 12'h000;

      // Reset state
      tick();
      chk("rst_bcd",  bcd, 16'h0000);
      chk("rst_zero", {15'h0, zero}, 16'h0001);
      chk("rst_wrap", {15'h0, wrap}, 16'h0000);
      chk("rst3_bcd", {4'h0, bcd3}, 16'h0000);

      // 75 up ticks -> 01:15
      reset = 1'b0; en = 1'b1; up = 1'b1;
      repeat (75) tick();
      en = 1'b0;
      chk("up75_bcd",  bcd, 16'h0115);
      chk("up75_zero", {15'h0, zero}, 16'h0000);

      // Up rollover 59:58 -> 59:59 -> 00:00
      load = 1'b1; load_val = 16'h5958;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      chk("roll_ld", bcd, 16'h5958);
      chk("roll_tc0", {15'h0, tc}, 16'h0000);
      tick();
      chk("roll_5959", bcd, 16'h5959);
      chk("roll_tc1", {15'h0, tc}, 16'h0001);
      chk("roll_wrap0", {15'h0, wrap}, 16'h0000);
      tick();
      en = 1'b0;
      chk("roll_0000", bcd, 16'h0000);
      chk("roll_wrap1", {15'h0, wrap}, 16'h0001);
      chk("roll_zero", {15'h0, zero}, 16'h0001);
      chk("roll_tc_idle", {15'h0, tc}, 16'h0000);
      tick();
      chk("roll_wrap_end", {15'h0, wrap}, 16'h0000);

      // Down expiry from 00:03
      load = 1'b1; load_val = 16'h0003;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b0;
      tick();
      chk("dn_0002", bcd, 16'h0002);
      tick();
      chk("dn_0001", bcd, 16'h0001);
      tick();
      chk("dn_0000", bcd, 16'h0000);
      chk("dn_zero", {15'h0, zero}, 16'h0001);
`ifdef BCD_CHAIN_SATURATE_EN
      chk("dn_wrap_reach", {15'h0, wrap}, 16'h0001);
      chk("dn_tc_at0", {15'h0, tc}, 16'h0000);
`else
      chk("dn_wrap_reach", {15'h0, wrap}, 16'h0000);
      chk("dn_tc_at0", {15'h0, tc}, 16'h0001);
`endif
      tick();
      en = 1'b0;
`ifdef BCD_CHAIN_SATURATE_EN
      chk("dn_after", bcd, 16'h0000);
      chk("dn_after_wrap", {15'h0, wrap}, 16'h0000);
      chk("dn_after_zero", {15'h0, zero}, 16'h0001);
`else
      chk("dn_after", bcd, 16'h5959);
      chk("dn_after_wrap", {15'h0, wrap}, 16'h0001);
      chk("dn_after_zero", {15'h0, zero}, 16'h0000);
`endif

      // Load clamp and load-over-en priority
      load = 1'b1; en = 1'b1; up = 1'b1; load_val = 16'h7B9C;
      #1;
      chk("clamp_tc", {15'h0, tc}, 16'h0000);
      tick();
      chk("clamp_all", bcd, 16'h0000);
      chk("clamp_zero", {15'h0, zero}, 16'h0001);
      chk("clamp_wrap", {15'h0, wrap}, 16'h0000);
      load_val = 16'h5A39;
      tick();
      load = 1'b0; en = 1'b0;
      chk("clamp_part", bcd, 16'h5039);
      chk("clamp_part_zero", {15'h0, zero}, 16'h0000);

      // Mid-count reset
      load = 1'b1; load_val = 16'h2000;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b0;
      repeat (5) tick();
      chk("mid_1955", bcd, 16'h1955);
      reset = 1'b1;
      tick();
      chk("mid_rst_bcd", bcd, 16'h0000);
      chk("mid_rst_wrap", {15'h0, wrap}, 16'h0000);
      chk("mid_rst_zero", {15'h0, zero}, 16'h0001);
      // A borrow-out in the same cycle as reset must not produce a wrap.
      reset = 1'b0;
      #1;
`ifdef BCD_CHAIN_SATURATE_EN
      chk("pend_tc", {15'h0, tc}, 16'h0000);
`else
      chk("pend_tc", {15'h0, tc}, 16'h0001);
`endif
      reset = 1'b1;
      tick();
      chk("pend_wrap", {15'h0, wrap}, 16'h0000);
      chk("pend_bcd", bcd, 16'h0000);
      reset = 1'b0; en = 1'b0;

      // Direction toggling across a digit boundary
      load = 1'b1; load_val = 16'h0959;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      chk("tog_up1", bcd, 16'h1000);
      up = 1'b0;
      tick();
      chk("tog_dn", bcd, 16'h0959);
      up = 1'b1;
      tick();
      chk("tog_up2", bcd, 16'h1000);
      en = 1'b0;

      // 3-digit chain with moduli 2,10,10 wraps every 200 ticks
      reset3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (wrap3) wraps3++;
         if (i == 199) begin
            chk("m200_199", {4'h0, bcd3}, 16'h0199);
            chk("m200_tc", {15'h0, tc3}, 16'h0001);
         end
      end
      chk("m200_bcd", {4'h0, bcd3}, 16'h0000);
      chk("m200_wrap_now", {15'h0, wrap3}, 16'h0001);
      chk("m200_zero", {15'h0, zero3}, 16'h0001);
      en3 = 1'b0;
      tick();
      chk("m200_wrap_end", {15'h0, wrap3}, 16'h0000);
      chk("m200_wraps", wraps3[15:0], 16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
